// File: rtl/next_pc_unit_pkg.sv
// Shared types for the fetch next-PC unit: machine word, BTB entry layout, reset defaults.
package next_pc_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int    BTB_IDX_DEFAULT  = 6;

  // Tag is held zero-extended to a full word so the layout does not depend on BTB_IDX.
  typedef struct packed {
    logic        valid;
    word_t       tag;
    logic [29:0] target;
  } btb_entry_t;

  function automatic word_t target_to_pc(input logic [29:0] t);
    return {t, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch-side and resolve-side signal bundle of the next-PC unit.
interface next_pc_unit_if;
  import next_pc_unit_pkg::*;

  logic  ihit;
  logic  stall;
  logic  pred_fetch;
  word_t pc_fetch;
  logic  fetch_pred_taken;
  word_t fetch_pred_target;

  logic  res_valid;
  word_t res_pc;
  logic  res_taken;
  word_t res_target;
  logic  res_pred_taken;
  word_t res_pred_target;

  logic  flush;
  word_t branch_cnt;
  word_t mispred_cnt;

  modport slave (
    input  ihit, stall, pred_fetch,
    input  res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
    output pc_fetch, fetch_pred_taken, fetch_pred_target,
    output flush, branch_cnt, mispred_cnt
  );

  modport master (
    output ihit, stall, pred_fetch,
    output res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
    input  pc_fetch, fetch_pred_taken, fetch_pred_target,
    input  flush, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/next_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational read, edge write, valid bits cleared by reset.
module btb
  import next_pc_unit_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_DEFAULT,
  parameter int TAG_W = 30 - BTB_IDX_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [29:0]      wr_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [29:0]      tgt_mem [DEPTH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: it is only trusted behind its valid bit.
  always_ff @(posedge CLK) begin
    if (we) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  // Read sees the pre-write contents in a same-cycle collision.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = word_t'(tag_mem[rd_idx]);
    rd_entry.target = tgt_mem[rd_idx];
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with BTB-based next-PC prediction, mispredict redirect and branch counters.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int    BTB_IDX  = BTB_IDX_DEFAULT,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          CLK,
  input  logic          nRST,
  next_pc_unit_if.slave bus
);

  localparam int TAG_W = 30 - BTB_IDX;

  word_t              pc_q;
  word_t              pc_next;
  word_t              seq_pc;
  word_t              pred_target;
  word_t              redirect_pc;
  word_t              branch_cnt_q;
  word_t              mispred_cnt_q;
  btb_entry_t         rd_entry;
  logic               btb_hit;
  logic               pred_taken;
  logic               mispredict;
  logic               btb_we;
  logic [BTB_IDX-1:0] rd_idx;
  logic [BTB_IDX-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign rd_idx = pc_q[BTB_IDX+1:2];
  assign wr_idx = bus.res_pc[BTB_IDX+1:2];
  assign wr_tag = bus.res_pc[31:BTB_IDX+2];
  assign btb_we = bus.res_valid && bus.res_taken;

  btb #(
    .IDX_W (BTB_IDX),
    .TAG_W (TAG_W)
  ) u_btb (
    .CLK       (CLK),
    .nRST      (nRST),
    .rd_idx    (rd_idx),
    .rd_entry  (rd_entry),
    .we        (btb_we),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_target (bus.res_target[31:2])
  );

  // Fetch-side prediction
  assign btb_hit     = rd_entry.valid && (rd_entry.tag == word_t'(pc_q[31:BTB_IDX+2]));
  assign pred_taken  = btb_hit && bus.pred_fetch;
  assign seq_pc      = pc_q + 32'd4;
  assign pred_target = pred_taken ? target_to_pc(rd_entry.target) : seq_pc;

  // Resolve-side mispredict detection and redirect
  assign mispredict  = bus.res_valid &&
                       ((bus.res_taken != bus.res_pred_taken) ||
                        (bus.res_taken && (bus.res_target != bus.res_pred_target)));
  assign redirect_pc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;

  // A mispredict wins over stall and a missing imem word.
  always_comb begin
    pc_next = pred_target;
    if (mispredict) begin
      pc_next = redirect_pc;
    end else if (bus.stall || !bus.ihit) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bus.res_valid) branch_cnt_q  <= sat_inc(branch_cnt_q);
      if (mispredict)    mispred_cnt_q <= sat_inc(mispred_cnt_q);
    end
  end

  assign bus.pc_fetch          = pc_q;
  assign bus.fetch_pred_taken  = pred_taken;
  assign bus.fetch_pred_target = pred_target;
  assign bus.flush             = mispredict;
  assign bus.branch_cnt        = branch_cnt_q;
  assign bus.mispred_cnt       = mispred_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed and randomized bench for next_pc_unit against a slot-table reference model.
module tb_next_pc_unit;
  import next_pc_unit_pkg::*;

  localparam int BTB_IDX = 6;
  localparam int NSLOT   = 1 << BTB_IDX;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_fail;

  next_pc_unit_if bus ();

  next_pc_unit #(
    .BTB_IDX  (BTB_IDX),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each slot remembers the full branch PC and target last written there.
  bit    m_valid [NSLOT];
  word_t m_pc    [NSLOT];
  word_t m_tgt   [NSLOT];
  word_t m_pcf;
  word_t m_bcnt;
  word_t m_mcnt;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input word_t pc, input logic tk, input word_t tgt,
                         input logic ptk, input word_t ptgt);
    bus.res_valid       = 1'b1;
    bus.res_pc          = pc;
    bus.res_taken       = tk;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ptk;
    bus.res_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
  endtask

  function automatic int slot_of(input word_t pc);
    return int'((pc >> 2) % NSLOT);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nrst   = 1'b0;
    bus.ihit = 1'b1;
    bus.stall = 1'b0;
    bus.pred_fetch = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_pc = '0;
    bus.res_taken = 1'b0;
    bus.res_target = '0;
    bus.res_pred_taken = 1'b0;
    bus.res_pred_target = '0;

    #2;
    chk("reset_pc", bus.pc_fetch, 32'h0);
    chk("reset_bcnt", bus.branch_cnt, 32'h0);
    chk("reset_mcnt", bus.mispred_cnt, 32'h0);
    chk("reset_flush", word_t'(bus.flush), 32'h0);
    chk("reset_pt", word_t'(bus.fetch_pred_taken), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    #1;

    // Sequential fetch
    chk("seq_pc0", bus.pc_fetch, 32'h0);
    chk("seq_tgt0", bus.fetch_pred_target, 32'h4);
    tick(); chk("seq_pc4", bus.pc_fetch, 32'h4);
    tick(); chk("seq_pc8", bus.pc_fetch, 32'h8);
    tick(); chk("seq_pcC", bus.pc_fetch, 32'hC);
    chk("seq_pt", word_t'(bus.fetch_pred_taken), 32'h0);

    // Taken branch not predicted
    resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1; chk("mis_flush", word_t'(bus.flush), 32'h1);
    tick(); idle();
    chk("mis_pc", bus.pc_fetch, 32'h100);
    chk("mis_bcnt", bus.branch_cnt, 32'd1);
    chk("mis_mcnt", bus.mispred_cnt, 32'd1);
    #1; chk("idle_flush", word_t'(bus.flush), 32'h0);

    // Fetch 0x40 with predictor taken, then not taken
    resolve(32'h3C, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); idle();
    bus.pred_fetch = 1'b1;
    #1;
    chk("hit_pc", bus.pc_fetch, 32'h40);
    chk("hit_pt", word_t'(bus.fetch_pred_taken), 32'h1);
    chk("hit_tgt", bus.fetch_pred_target, 32'h100);
    tick(); chk("hit_next", bus.pc_fetch, 32'h100);
    resolve(32'h3C, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); idle();
    bus.pred_fetch = 1'b0;
    #1;
    chk("nt_pt", word_t'(bus.fetch_pred_taken), 32'h0);
    chk("nt_tgt", bus.fetch_pred_target, 32'h44);
    tick(); chk("nt_next", bus.pc_fetch, 32'h44);

    // Mispredict overrides stall; stall and ihit=0 hold
    bus.stall = 1'b1;
    resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    tick(); idle();
    chk("stall_redirect", bus.pc_fetch, 32'h200);
    tick(); chk("stall_hold", bus.pc_fetch, 32'h200);
    bus.stall = 1'b0;
    bus.ihit  = 1'b0;
    tick(); chk("ihit_hold", bus.pc_fetch, 32'h200);
    bus.ihit = 1'b1;
    tick(); chk("resume", bus.pc_fetch, 32'h204);
    chk("cnt4_b", bus.branch_cnt, 32'd4);
    chk("cnt4_m", bus.mispred_cnt, 32'd4);

    // Aliasing: 0x140 shares the slot of 0x40 with a different tag
    resolve(32'h13C, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); idle();
    bus.pred_fetch = 1'b1;
    #1;
    chk("alias_pc", bus.pc_fetch, 32'h140);
    chk("alias_pt", word_t'(bus.fetch_pred_taken), 32'h0);
    tick(); chk("alias_next", bus.pc_fetch, 32'h144);

    // Same-cycle write and lookup; target low bits dropped
    resolve(32'h144, 1'b1, 32'h303, 1'b1, 32'h303);
    #1;
    chk("coll_flush", word_t'(bus.flush), 32'h0);
    chk("coll_pt", word_t'(bus.fetch_pred_taken), 32'h0);
    tick();
    chk("coll_next", bus.pc_fetch, 32'h148);
    resolve(32'h140, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); idle();
    #1;
    chk("lowbits_pt", word_t'(bus.fetch_pred_taken), 32'h1);
    chk("lowbits_tgt", bus.fetch_pred_target, 32'h300);
    tick(); chk("lowbits_next", bus.pc_fetch, 32'h300);
    chk("cnt7_b", bus.branch_cnt, 32'd7);
    chk("cnt6_m", bus.mispred_cnt, 32'd6);

    // Wrong target on a correctly predicted taken branch
    resolve(32'h300, 1'b1, 32'h40, 1'b1, 32'h80);
    #1; chk("tgt_flush", word_t'(bus.flush), 32'h1);
    tick();
    chk("tgt_pc", bus.pc_fetch, 32'h40);

    // Reset in the middle of a redirect
    resolve(32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_mid_pc", bus.pc_fetch, 32'h0);
    chk("rst_mid_b", bus.branch_cnt, 32'h0);
    chk("rst_mid_m", bus.mispred_cnt, 32'h0);
    tick(); chk("rst_hold_pc", bus.pc_fetch, 32'h0);
    idle();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("post_rst_pt", word_t'(bus.fetch_pred_taken), 32'h0);

    // Randomized run against the model
    for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
    m_pcf  = 32'h0;
    m_bcnt = 32'h0;
    m_mcnt = 32'h0;
    for (int n = 0; n < 400; n++) begin
      int    s;
      bit    hit;
      bit    exp_pt;
      bit    mis;
      word_t exp_tgt;
      bus.ihit            = ($urandom % 4) != 0;
      bus.stall           = ($urandom % 5) == 0;
      bus.pred_fetch      = ($urandom % 4) != 0;
      bus.res_valid       = ($urandom % 3) == 0;
      bus.res_pc          = $urandom_range(0, 127) * 4;
      bus.res_taken       = $urandom % 2;
      bus.res_target      = $urandom_range(0, 127) * 4;
      bus.res_pred_taken  = $urandom % 2;
      bus.res_pred_target = ($urandom % 2) ? bus.res_target : $urandom_range(0, 127) * 4;
      #1;
      s       = slot_of(m_pcf);
      hit     = m_valid[s] && (m_pc[s] == (m_pcf & ~32'h3));
      exp_pt  = hit && bus.pred_fetch;
      exp_tgt = exp_pt ? m_tgt[s] : m_pcf + 32'd4;
      mis     = bus.res_valid && ((bus.res_taken != bus.res_pred_taken) ||
                (bus.res_taken && bus.res_target != bus.res_pred_target));
      chk("rnd_pc", bus.pc_fetch, m_pcf);
      chk("rnd_pt", word_t'(bus.fetch_pred_taken), word_t'(exp_pt));
      chk("rnd_tgt", bus.fetch_pred_target, exp_tgt);
      chk("rnd_flush", word_t'(bus.flush), word_t'(mis));
      if (mis) m_pcf = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
      else if (!(bus.stall || !bus.ihit)) m_pcf = exp_tgt;
      if (bus.res_valid && bus.res_taken) begin
        m_valid[slot_of(bus.res_pc)] = 1'b1;
        m_pc[slot_of(bus.res_pc)]    = bus.res_pc & ~32'h3;
        m_tgt[slot_of(bus.res_pc)]   = bus.res_target & ~32'h3;
      end
      if (bus.res_valid && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
      if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
      tick();
      chk("rnd_bcnt", bus.branch_cnt, m_bcnt);
      chk("rnd_mcnt", bus.mispred_cnt, m_mcnt);
    end
    chk("rnd_final_pc", bus.pc_fetch, m_pcf);

    // Counter saturation
    idle();
    force dut.branch_cnt_q  = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    resolve(32'h10, 1'b1, 32'h20, 1'b0, 32'h0);
    #1;
    chk("sat_flush", word_t'(bus.flush), 32'h1);
    tick(); idle();
    chk("sat_b", bus.branch_cnt, 32'hFFFF_FFFF);
    chk("sat_m", bus.mispred_cnt, 32'hFFFF_FFFF);
    nrst = 1'b0;
    #1;
    chk("final_rst_b", bus.branch_cnt, 32'h0);
    chk("final_rst_m", bus.mispred_cnt, 32'h0);
    chk("final_rst_pc", bus.pc_fetch, 32'h0);
    nrst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 The module SHALL take parameter BTB_IDX, default 6, meaning log2 of BTB entry count (64 entries).
REQ-002 The module SHALL take parameter RESET_PC, default 32'h0000_0000, meaning fetch PC after reset.
REQ-003 The module SHALL have port CLK  in  1  clock, rising edge.
REQ-004 The module SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port ihit  in  1  instruction memory returned the word at pc_fetch this cycle.
REQ-006 The module SHALL have port stall  in  1  downstream hold; fetch stage not accepting.
REQ-007 The module SHALL have port pred_fetch  in  1  direction predictor output for pc_fetch (1 = taken).
REQ-008 The module SHALL have port pc_fetch  out  32  current fetch PC, to imem and direction predictor.
REQ-009 The module SHALL have port fetch_pred_taken  out  1  final prediction for pc_fetch, carried down pipeline.
REQ-010 The module SHALL have port fetch_pred_target  out  32  predicted next PC for pc_fetch, carried down pipeline.
REQ-011 The module SHALL have port res_valid  in  1  a branch/jump resolves this cycle.
REQ-012 The module SHALL have ports res_pc  in  32, res_taken  in  1, res_target  in  32, res_pred_taken  in  1, res_pred_target  in  32: resolved branch PC, outcome, actual target, and prediction carried from fetch.
REQ-013 The module SHALL have port flush  out  1  mispredict; squash younger instructions.
REQ-014 The module SHALL have ports branch_cnt  out  32 and mispred_cnt  out  32: saturating performance counters.

Function
REQ-015 BTB SHALL be direct-mapped, 2**BTB_IDX entries of {valid, tag = pc[31:BTB_IDX+2], target[31:2]}, indexed by pc[BTB_IDX+1:2].
REQ-016 btb_hit SHALL be valid && tag match for pc_fetch, combinational.
REQ-017 fetch_pred_taken SHALL equal btb_hit && pred_fetch; fetch_pred_target SHALL be BTB target when fetch_pred_taken, else pc_fetch+4 (32-bit wrap).
REQ-018 mispredict SHALL be res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)); flush SHALL equal mispredict, combinational, same cycle.
REQ-019 Redirect PC SHALL be res_target if res_taken, else res_pc+4.
REQ-020 Next-PC priority at each edge: mispredict -> redirect PC; else stall || !ihit -> hold; else fetch_pred_target.
REQ-021 Mispredict SHALL override stall and ihit.
REQ-022 On res_valid && res_taken, BTB entry SHALL be written {1, tag(res_pc), res_target[31:2]} at edge; on res_valid && !res_taken, entry unchanged.
REQ-023 Same-cycle lookup and write to same index SHALL read pre-write contents; write visible next cycle.
REQ-024 branch_cnt SHALL increment on res_valid; mispred_cnt on mispredict; both SHALL saturate at 32'hFFFF_FFFF.
REQ-025 Target low bits [1:0] SHALL not be stored; reconstructed as 2'b00.

Reset
REQ-026 On nRST low: pc_fetch = RESET_PC, all BTB valid bits = 0, counters = 0, immediately and asynchronously.
REQ-027 After reset, flush = 0 while res_valid = 0; fetch_pred_taken = 0 until first BTB write.
REQ-028 Reset mid-redirect SHALL discard the redirect; PC = RESET_PC.

Structure
REQ-029 Shared package SHALL hold word_t (32 bits), btb_entry_t struct, and RESET_PC default.
REQ-030 BTB storage SHALL be sub-module btb (read port, write port, valid clear on reset).
REQ-031 PC register, next-PC mux, mispredict detect, and counters SHALL stay in next_pc_unit.

Verification
REQ-032 Reset, ihit=1, no branches -> pc_fetch 0x0, 0x4, 0x8, 0xC on successive edges; fetch_pred_taken = 0.
REQ-033 Resolve taken res_pc=0x40, target=0x100, pred_taken=0 -> flush=1 that cycle, pc_fetch=0x100 next edge, mispred_cnt=1, branch_cnt=1.
REQ-034 Later fetch 0x40 with pred_fetch=1 -> fetch_pred_taken=1, target 0x100, next pc 0x100; with pred_fetch=0 -> next pc 0x44.
REQ-035 stall=1 plus mispredict to 0x200 in same cycle -> pc_fetch=0x200 next edge; stall=1 alone holds pc.
REQ-036 Aliasing: BTB entry for 0x40, fetch 0x40+(4<<BTB_IDX)=0x140 -> btb_hit=0, next pc 0x144.
REQ-037 Counters preloaded to 0xFFFF_FFFF via force, mispredict -> both remain 0xFFFF_FFFF; nRST pulse -> both 0, pc 0x0.
